// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width; a single-digit adder still needs one counter bit.
  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from a chain of full-adder cells.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[DIGIT];

endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial WIDTH-bit adder: one DIGIT-bit slice, LSB digit first, start/done handshake.
// Optional subtract mode (port sub) is compiled in with MULTICYCLE_ADDER_SUBTRACT_EN.
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_w(NDIG);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .a  (a_q[DIGIT-1:0]),
    .b  (b_q[DIGIT-1:0]),
    .ci (c_q),
    .s  (dig_s),
    .co (dig_co)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (cnt_q == CW'(NDIG - 1));

`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
  // Two's-complement subtract: invert B and seed the carry with 1.
  assign b_load = sub ? ~B : B;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = B;
  assign c_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        c_d    = dig_co;
        cnt_d  = cnt_q + CW'(1);
        // New digit enters at the top so the LSB digit ends up at bit 0.
        psum_d = (psum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        if (last) begin
          state_d = DONE;
          sum_d   = psum_d;
          carry_d = dig_co;
        end
      end
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d   = A;
      b_d   = b_load;
      c_d   = c_load;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench: three instances (DIGIT = 1, 4, 8) share stimulus; vectors, corner sequences and random ops.
module tb_multicycle_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       cin;
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
  logic       sub_r = 1'b0;
`endif

  logic       busy_w  [3];
  logic       done_w  [3];
  logic [7:0] sum_w   [3];
  logic       carry_w [3];

  int         nd [3] = '{8, 2, 1};
  logic [7:0] prev_s [3];
  logic       prev_c [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    .sub(sub_r),
`endif
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .carry(carry_w[0]));

  multicycle_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    .sub(sub_r),
`endif
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .carry(carry_w[1]));

  multicycle_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    .sub(sub_r),
`endif
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum_w[2]), .carry(carry_w[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       s;
    logic [7:0] es;
    logic       ec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic s);
    int r;
    logic c;
    if (s) begin
      r = (int'(a) - int'(b)) & 255;
      c = (a >= b);
    end else begin
      r = int'(a) + int'(b) + int'(ci);
      c = (r > 255);
      r = r & 255;
    end
    return {c, r[7:0]};
  endfunction

  // One operation on all three instances; checks latency, result and hold-during-RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] es, input logic ec, input string tag);
    int seen [3];
    @(negedge clk);
    A = a; B = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, 32'(busy_w[i]), 32'd1);
      seen[i] = -1;
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (seen[i] < 0) begin
          if (done_w[i]) begin
            seen[i] = k;
            chk({tag, "_sum"}, 32'(sum_w[i]), 32'(es));
            chk({tag, "_carry"}, 32'(carry_w[i]), 32'(ec));
            prev_s[i] = es;
            prev_c[i] = ec;
          end else begin
            chk({tag, "_hold_sum"}, 32'(sum_w[i]), 32'(prev_s[i]));
            chk({tag, "_hold_carry"}, 32'(carry_w[i]), 32'(prev_c[i]));
          end
        end
      end
    end
    for (int i = 0; i < 3; i++) chk({tag, "_latency"}, 32'(seen[i]), 32'(nd[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    int   dn;
    int   seen;
    int   dt   [3][3];
    int   cntd [3];

    vecs.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
    vecs.push_back('{8'h9A, 8'h77, 1'b0, 1'b0, 8'h11, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
    vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
    vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0});
    vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0});
`endif

    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; cin = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy_w[i]), 32'd0);
      chk("rst_done", 32'(done_w[i]), 32'd0);
      chk("rst_sum", 32'(sum_w[i]), 32'd0);
      chk("rst_carry", 32'(carry_w[i]), 32'd0);
      prev_s[i] = 8'h00;
      prev_c[i] = 1'b0;
    end
    rst = 1'b0;

    foreach (vecs[v]) begin
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
      sub_r = vecs[v].s;
`endif
      run_op(vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].es, vecs[v].ec, "vec");
    end
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
    sub_r = 1'b0;
`endif

    // start re-asserted mid-RUN on the DIGIT=1 instance must be ignored
    @(negedge clk);
    A = 8'h3C; B = 8'h05; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    A = 8'h01; B = 8'h01; start = 1'b1;
    seen = -1;
    dn = 0;
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      if (k == 4) start = 1'b0;
      if (done_w[0]) begin
        if (seen < 0) begin
          seen = k;
          chk("midstart_sum", 32'(sum_w[0]), 32'h41);
          chk("midstart_carry", 32'(carry_w[0]), 32'd0);
        end else dn++;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    chk("midstart_latency", 32'(seen), 32'd8);
    chk("midstart_extra_done", 32'(dn), 32'd0);
    chk("midstart_d4_second_op", 32'(sum_w[1]), 32'h02);
    chk("midstart_d8_second_op", 32'(sum_w[2]), 32'h02);
    prev_s[0] = 8'h41; prev_s[1] = 8'h02; prev_s[2] = 8'h02;
    for (int i = 0; i < 3; i++) prev_c[i] = 1'b0;

    // start held high: back-to-back ops every NDIG+1 cycles
    @(negedge clk);
    A = 8'h9A; B = 8'h77; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cntd[i] = 0;
      for (int j = 0; j < 3; j++) dt[i][j] = -1;
    end
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_w[i] && cntd[i] < 3) begin
          dt[i][cntd[i]] = k;
          cntd[i]++;
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk("held_done_time", 32'(dt[i][j]), 32'(nd[i] + j * (nd[i] + 1)));
    repeat (12) @(negedge clk);
    chk("held_sum", 32'(sum_w[0]), 32'h11);
    for (int i = 0; i < 3; i++) begin
      prev_s[i] = 8'h11;
      prev_c[i] = 1'b1;
    end

    // reset three cycles into RUN aborts without a done pulse
    @(negedge clk);
    A = 8'hFF; B = 8'h01; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(busy_w[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_done", 32'(done_w[0]), 32'd0);
    chk("abort_sum", 32'(sum_w[0]), 32'd0);
    chk("abort_carry", 32'(carry_w[0]), 32'd0);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_w[0]) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    for (int i = 0; i < 3; i++) begin
      prev_s[i] = 8'h00;
      prev_c[i] = 1'b0;
    end
    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "after_abort");

    for (int n = 0; n < 20; n++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      logic [8:0] exp;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
      rs    = 1'($urandom);
      sub_r = rs;
`endif
      exp = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, exp[7:0], exp[8], "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
